// File: rtl/adr_multiport_regfile_pkg.sv
// Shared ADR definitions used by the integer register file and its clear sequencer.
package adr_multiport_regfile_pkg;

  localparam int ADR_XLEN          = 32;
  localparam int ADR_NUM_ARCH_REGS = 32;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_clr_state_e;

endpackage

// File: rtl/adr_rf_clear_seq.sv
// Post-reset clear sequencer: walks every entry once writing zero, then holds READY.
//   state    | meaning
//   RF_CLEAR | zeroing entry clr_cnt each edge; user writes ignored, reads return 0
//   RF_READY | array cleared, user ports live until the next reset
module adr_rf_clear_seq
  import adr_multiport_regfile_pkg::*;
#(
  parameter int DEPTH = ADR_NUM_ARCH_REGS
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     clr_we,
  output logic [$clog2(DEPTH)-1:0] clr_addr,
  output logic                     ready_o
);

  localparam int AW = $clog2(DEPTH);

  rf_clr_state_e state, state_nxt;
  logic [AW-1:0] clr_cnt, clr_cnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RF_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    if (state == RF_CLEAR) begin
      clr_cnt_nxt = clr_cnt + AW'(1);
      if (clr_cnt == AW'(DEPTH - 1)) state_nxt = RF_READY;
    end
  end

  // Outputs decode the state register only, so ready_o has no input-to-output path.
  always_comb begin
    clr_we   = (state == RF_CLEAR);
    clr_addr = clr_cnt;
    ready_o  = (state == RF_READY);
  end

endmodule

// File: rtl/adr_multiport_regfile.sv
// Multi-port integer register file: registered reads, prioritised writes, optional
// write-first bypass and hardwired-zero entry 0; storage is zeroed by a clear sequence.
module adr_multiport_regfile
  import adr_multiport_regfile_pkg::*;
#(
  parameter int XLEN     = ADR_XLEN,
  parameter int DEPTH    = ADR_NUM_ARCH_REGS,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_RD-1:0]                     rd_en_i,
  input  logic [NUM_RD-1:0][$clog2(DEPTH)-1:0]  rd_addr_i,
  output logic [NUM_RD-1:0][XLEN-1:0]           rd_data_o,
  input  logic [NUM_WR-1:0]                     wr_en_i,
  input  logic [NUM_WR-1:0][$clog2(DEPTH)-1:0]  wr_addr_i,
  input  logic [NUM_WR-1:0][XLEN-1:0]           wr_data_i,
  output logic                                  ready_o
);

  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0]              mem [DEPTH];
  logic                         clr_we;
  logic [AW-1:0]                clr_addr;
  logic [NUM_RD-1:0][XLEN-1:0]  rd_next;

  // Addresses beyond DEPTH and the hardwired zero entry neither store nor return data.
  function automatic logic live_addr(input logic [AW-1:0] a);
    return (32'(a) < 32'(DEPTH)) && !(ZERO_REG && (a == '0));
  endfunction

  adr_rf_clear_seq #(
    .DEPTH (DEPTH)
  ) u_clear_seq (
    .clk      (clk),
    .reset    (reset),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .ready_o  (ready_o)
  );

  // Later loop iterations override earlier ones, so the highest write port wins.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en_i[w] && live_addr(wr_addr_i[w])) mem[wr_addr_i[w]] <= wr_data_i[w];
      end
    end
  end

  always_comb begin
    rd_next = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      if (ready_o && live_addr(rd_addr_i[r])) begin
        rd_next[r] = mem[rd_addr_i[r]];
        if (BYPASS) begin
          for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en_i[w] && (wr_addr_i[w] == rd_addr_i[r])) rd_next[r] = wr_data_i[w];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_o <= '0;
    end else begin
      for (int r = 0; r < NUM_RD; r++) begin
        if (rd_en_i[r]) rd_data_o[r] <= rd_next[r];
      end
    end
  end

endmodule

// File: tb/tb_adr_multiport_regfile.sv
// Directed bench: default file (a), BYPASS=0 file (b), two-writer DEPTH=24 file (c).
module tb_adr_multiport_regfile;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [1:0]        a_rd_en, b_rd_en, c_rd_en;
  logic [1:0][4:0]   a_rd_addr, b_rd_addr, c_rd_addr;
  logic [1:0][31:0]  a_rd_data, b_rd_data, c_rd_data;
  logic [0:0]        a_wr_en, b_wr_en;
  logic [0:0][4:0]   a_wr_addr, b_wr_addr;
  logic [0:0][31:0]  a_wr_data, b_wr_data;
  logic [1:0]        c_wr_en;
  logic [1:0][4:0]   c_wr_addr;
  logic [1:0][31:0]  c_wr_data;
  logic              a_ready, b_ready, c_ready;

  adr_multiport_regfile u_a (
    .clk(clk), .reset(reset),
    .rd_en_i(a_rd_en), .rd_addr_i(a_rd_addr), .rd_data_o(a_rd_data),
    .wr_en_i(a_wr_en), .wr_addr_i(a_wr_addr), .wr_data_i(a_wr_data),
    .ready_o(a_ready)
  );

  adr_multiport_regfile #(.BYPASS(1'b0)) u_b (
    .clk(clk), .reset(reset),
    .rd_en_i(b_rd_en), .rd_addr_i(b_rd_addr), .rd_data_o(b_rd_data),
    .wr_en_i(b_wr_en), .wr_addr_i(b_wr_addr), .wr_data_i(b_wr_data),
    .ready_o(b_ready)
  );

  adr_multiport_regfile #(.DEPTH(24), .NUM_WR(2)) u_c (
    .clk(clk), .reset(reset),
    .rd_en_i(c_rd_en), .rd_addr_i(c_rd_addr), .rd_data_o(c_rd_data),
    .wr_en_i(c_wr_en), .wr_addr_i(c_wr_addr), .wr_data_i(c_wr_data),
    .ready_o(c_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_rd_en = '0; b_rd_en = '0; c_rd_en = '0;
    a_wr_en = '0; b_wr_en = '0; c_wr_en = '0;
    a_rd_addr = '0; b_rd_addr = '0; c_rd_addr = '0;
    a_wr_addr = '0; b_wr_addr = '0; c_wr_addr = '0;
    a_wr_data = '0; b_wr_data = '0; c_wr_data = '0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    step();
    step();
    total++;
    if (a_ready !== 1'b0 || a_rd_data !== '0) begin
      bad++;
      $display("FAIL reset_state ready=%b rd=%h expected ready=0 rd=0", a_ready, a_rd_data);
    end
    reset = 1'b0;
    // Enabled reads during the clear must return zero.
    a_rd_en = 2'b11;
    a_rd_addr[0] = 5'd3;
    a_rd_addr[1] = 5'd31;
    for (int k = 1; k <= 32; k++) begin
      step();
      total++;
      if (a_ready !== (k >= 32) || b_ready !== (k >= 32) || c_ready !== (k >= 24)) begin
        bad++;
        $display("FAIL clear_ready edge=%0d a=%b b=%b c=%b expected a=%b c=%b",
                 k, a_ready, b_ready, c_ready, (k >= 32), (k >= 24));
      end
      if (k == 16) begin
        total++;
        if (a_rd_data !== '0) begin
          bad++;
          $display("FAIL clear_read got=%h expected 0", a_rd_data);
        end
      end
    end
    idle();
  endtask

  task automatic test_read_zero();
    a_rd_en = 2'b11;
    for (int i = 0; i < 32; i++) begin
      a_rd_addr[0] = 5'(i);
      a_rd_addr[1] = 5'(31 - i);
      step();
      total++;
      if (a_rd_data !== '0) begin
        bad++;
        $display("FAIL read_zero addr=%0d got=%h expected 0", i, a_rd_data);
      end
    end
    idle();
  endtask

  task automatic test_bypass();
    a_wr_en = 1'b1; a_wr_addr[0] = 5'd5; a_wr_data[0] = 32'hDEADBEEF;
    b_wr_en = 1'b1; b_wr_addr[0] = 5'd5; b_wr_data[0] = 32'hDEADBEEF;
    a_rd_en = 2'b01; a_rd_addr[0] = 5'd5;
    b_rd_en = 2'b01; b_rd_addr[0] = 5'd5;
    step();
    total++;
    if (a_rd_data[0] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL bypass_same_cycle got=%h expected deadbeef", a_rd_data[0]);
    end
    total++;
    if (b_rd_data[0] !== 32'h0) begin
      bad++;
      $display("FAIL nobypass_same_cycle got=%h expected 0", b_rd_data[0]);
    end
    a_wr_en = '0; b_wr_en = '0;
    step();
    total++;
    if (a_rd_data[0] !== 32'hDEADBEEF || b_rd_data[0] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL next_cycle_read a=%h b=%h expected deadbeef", a_rd_data[0], b_rd_data[0]);
    end
    idle();
  endtask

  task automatic test_priority();
    c_wr_en = 2'b11;
    c_wr_addr[0] = 5'd7; c_wr_data[0] = 32'h11;
    c_wr_addr[1] = 5'd7; c_wr_data[1] = 32'h22;
    c_rd_en = 2'b01; c_rd_addr[0] = 5'd7;
    step();
    total++;
    if (c_rd_data[0] !== 32'h22) begin
      bad++;
      $display("FAIL priority_bypass got=%h expected 22", c_rd_data[0]);
    end
    c_wr_addr[0] = 5'd8; c_wr_data[0] = 32'h33;
    c_wr_addr[1] = 5'd9; c_wr_data[1] = 32'h44;
    c_rd_en = 2'b00;
    step();
    c_wr_en = '0;
    c_rd_en = 2'b11; c_rd_addr[0] = 5'd7; c_rd_addr[1] = 5'd8;
    step();
    total++;
    if (c_rd_data[0] !== 32'h22 || c_rd_data[1] !== 32'h33) begin
      bad++;
      $display("FAIL priority_stored a7=%h a8=%h expected 22 33", c_rd_data[0], c_rd_data[1]);
    end
    c_rd_addr[0] = 5'd9;
    step();
    total++;
    if (c_rd_data[0] !== 32'h44) begin
      bad++;
      $display("FAIL dual_write_port1 got=%h expected 44", c_rd_data[0]);
    end
    idle();
  endtask

  task automatic test_zero_reg();
    a_wr_en = 1'b1; a_wr_addr[0] = 5'd0; a_wr_data[0] = 32'hFFFFFFFF;
    a_rd_en = 2'b01; a_rd_addr[0] = 5'd0;
    step();
    total++;
    if (a_rd_data[0] !== 32'h0) begin
      bad++;
      $display("FAIL zero_reg_bypass got=%h expected 0", a_rd_data[0]);
    end
    a_wr_en = '0;
    step();
    total++;
    if (a_rd_data[0] !== 32'h0) begin
      bad++;
      $display("FAIL zero_reg_stored got=%h expected 0", a_rd_data[0]);
    end
    idle();
  endtask

  task automatic test_out_of_range();
    c_wr_en = 2'b01; c_wr_addr[0] = 5'd30; c_wr_data[0] = 32'h5A5A5A5A;
    c_rd_en = 2'b01; c_rd_addr[0] = 5'd30;
    step();
    total++;
    if (c_rd_data[0] !== 32'h0) begin
      bad++;
      $display("FAIL oor_bypass got=%h expected 0", c_rd_data[0]);
    end
    c_wr_en = '0;
    c_rd_en = 2'b11; c_rd_addr[1] = 5'd6;
    step();
    total++;
    if (c_rd_data[0] !== 32'h0 || c_rd_data[1] !== 32'h0) begin
      bad++;
      $display("FAIL oor_stored a30=%h a6=%h expected 0 0", c_rd_data[0], c_rd_data[1]);
    end
    idle();
  endtask

  task automatic test_reset_mid_clear();
    a_rd_en = 2'b10; a_rd_addr[1] = 5'd5;
    step();
    total++;
    if (a_rd_data[1] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL preload got=%h expected deadbeef", a_rd_data[1]);
    end
    idle();
    #2 reset = 1'b1;
    #1;
    total++;
    if (a_rd_data !== '0 || a_ready !== 1'b0) begin
      bad++;
      $display("FAIL async_reset rd=%h ready=%b expected 0 0", a_rd_data, a_ready);
    end
    step();
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) step();
    #2 reset = 1'b1;
    #1;
    total++;
    if (a_ready !== 1'b0 || c_ready !== 1'b0 || a_rd_data !== '0) begin
      bad++;
      $display("FAIL mid_clear_reset a=%b c=%b rd=%h expected 0 0 0", a_ready, c_ready, a_rd_data);
    end
    step();
    reset = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      if (k >= 5) begin
        a_wr_en = 1'b1; a_wr_addr[0] = 5'd2; a_wr_data[0] = 32'h00001234;
      end
      step();
      total++;
      if (a_ready !== (k == 32)) begin
        bad++;
        $display("FAIL restart_ready edge=%0d got=%b expected %b", k, a_ready, (k == 32));
      end
    end
    idle();
    a_rd_en = 2'b01; a_rd_addr[0] = 5'd2;
    step();
    total++;
    if (a_rd_data[0] !== 32'h0) begin
      bad++;
      $display("FAIL write_while_clearing got=%h expected 0", a_rd_data[0]);
    end
    idle();
  endtask

  task automatic test_read_hold();
    a_wr_en = 1'b1; a_wr_addr[0] = 5'd4; a_wr_data[0] = 32'hCAFE0001;
    step();
    a_wr_en = '0;
    a_rd_en = 2'b10; a_rd_addr[1] = 5'd4;
    step();
    total++;
    if (a_rd_data[1] !== 32'hCAFE0001) begin
      bad++;
      $display("FAIL hold_load got=%h expected cafe0001", a_rd_data[1]);
    end
    a_rd_en = 2'b01; a_rd_addr[0] = 5'd4;
    a_wr_en = 1'b1; a_wr_data[0] = 32'hCAFE0002;
    step();
    a_wr_en = '0;
    step();
    total++;
    if (a_rd_data[1] !== 32'hCAFE0001 || a_rd_data[0] !== 32'hCAFE0002) begin
      bad++;
      $display("FAIL hold_across_write p1=%h p0=%h expected cafe0001 cafe0002",
               a_rd_data[1], a_rd_data[0]);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    for (int i = 10; i < 14; i++) begin
      a_wr_en = 1'b1; a_wr_addr[0] = 5'(i); a_wr_data[0] = 32'hA000_0000 + 32'(i);
      a_rd_en = 2'b10; a_rd_addr[1] = 5'(i - 1);
      step();
      if (i > 10) begin
        total++;
        if (a_rd_data[1] !== 32'hA000_0000 + 32'(i - 1)) begin
          bad++;
          $display("FAIL back_to_back addr=%0d got=%h expected %h",
                   i - 1, a_rd_data[1], 32'hA000_0000 + 32'(i - 1));
        end
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_read_zero();
    test_bypass();
    test_priority();
    test_zero_reg();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_clear();
    test_read_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adr_multiport_regfile.md
# adr_multiport_regfile

Parametrised integer register file for the ADR core: DEPTH entries of XLEN bits, NUM_RD synchronous read ports and NUM_WR write ports. It extends the single-write, dual-read file with an optional hardwired-zero entry 0, deterministic multi-writer priority, optional same-cycle write-to-read bypass, and a post-reset clear sequencer that zeroes the array without an asynchronous reset on the storage. It sits between decode (read ports) and writeback (write ports).

## Interface
- XLEN, 32, data width in bits
- DEPTH, 32, number of entries (≥2; need not be a power of two)
- NUM_RD, 2, read ports (1–4)
- NUM_WR, 1, write ports (1–2)
- ZERO_REG, 1, entry 0 reads 0 and ignores writes
- BYPASS, 1, same-cycle write data is forwarded to reads (write-first)
- AW, $clog2(DEPTH), address width (derived; not overridable)
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- rd_en_i  in  NUM_RD  per-port read enable
- rd_addr_i  in  NUM_RD×AW  read addresses
- rd_data_o  out  NUM_RD×XLEN  registered read data
- wr_en_i  in  NUM_WR  per-port write enable
- wr_addr_i  in  NUM_WR×AW  write addresses
- wr_data_i  in  NUM_WR×XLEN  write data
- ready_o  out  1  high once the array is cleared and accepting writes

## Operation
- Clear FSM, two states, CLEAR and READY. reset forces CLEAR, clr_cnt=0.
- CLEAR: each edge writes 0 to entry clr_cnt, clr_cnt+1; on the edge that clears DEPTH-1, go to READY. No exit from READY except reset.
- In CLEAR, wr_en_i is ignored and enabled reads return 0.
- READY: writes with wr_en_i[w]=1 commit on the edge. If several ports target the same address, the highest-indexed port wins.
- Reads: with rd_en_i[r]=1, rd_data_o[r] loads the entry on the edge. With rd_en_i[r]=0, rd_data_o[r] holds its value.
- BYPASS=1: if a committing write targets the read address in the same cycle, the read returns the new data, using the same highest-port priority. BYPASS=0: the read returns the pre-write contents.
- ZERO_REG=1: address 0 always reads 0, and writes to it are dropped, including during bypass.
- Address ≥ DEPTH: reads return 0 and writes are dropped.

## Timing
- Reset values: rd_data_o all 0, ready_o 0, state CLEAR, clr_cnt 0.
- Read latency is 1 cycle. The address is presented in cycle N and the data is valid after the edge that ends cycle N.
- Write-to-read: a read in cycle N+1 of an address written in cycle N sees the new data in all modes. Same-cycle visibility depends only on BYPASS.
- ready_o rises after exactly DEPTH rising edges following reset deassertion. It is registered, with no combinational path from inputs.
- If reset is asserted mid-clear or mid-operation, all outputs and the FSM return to reset values immediately, and the clear restarts from 0 after deassertion.
- No handshake on read or write ports. The producer must gate writes on ready_o; writes issued while ready_o=0 are lost silently.

## Structure
- The shared ADR package holds:
  - the XLEN default;
  - the architectural register count (32);
  - the enum rf_clr_state_e {RF_CLEAR, RF_READY}.
- Sub-module adr_rf_clear_seq contains the FSM, clr_cnt, ready_o, and the clear write-enable/address outputs. The top module muxes the clear write into the array ahead of the user ports.
- Array: plain unpacked logic array with no reset, written in one always_ff. Read/bypass selection is combinational, registered into rd_data_o.

## Test plan
- Defaults: release reset → ready_o=0 for 32 edges, then 1. Every address then reads 0x00000000.
- Write 0xDEADBEEF to address 5 and, in the same cycle, read address 5. Required: 0xDEADBEEF with BYPASS=1, 0x00000000 with BYPASS=0. The next-cycle read returns 0xDEADBEEF in both modes.
- NUM_WR=2, both ports write address 7 (port0 0x11, port1 0x22) → address 7 reads 0x22. A same-cycle bypass read also returns 0x22.
- ZERO_REG=1: write 0xFFFFFFFF to address 0 → reads 0.
- DEPTH=24: write address 30 → dropped; reading address 30 returns 0.
- Assert reset at clear cycle 10, release, write during ready_o=0 → write lost. ready_o rises DEPTH edges after the second release. rd_data_o=0 throughout reset. A held rd_en_i=0 port keeps its value across later writes.
